// File: rtl/mux4_reg_pkg.sv
// mux4_reg_pkg: shared constants for the registered 4:1 operand multiplexer.
//   SEL_IN1..SEL_IN4 : ctrl encodings selecting in1..in4
//   DATA_W_DEFAULT   : default operand width
//   SEL_W            : width of the select control
package mux4_reg_pkg;

    localparam int unsigned DATA_W_DEFAULT = 64;
    localparam int unsigned SEL_W          = 2;

    localparam logic [SEL_W-1:0] SEL_IN1 = 2'd0;
    localparam logic [SEL_W-1:0] SEL_IN2 = 2'd1;
    localparam logic [SEL_W-1:0] SEL_IN3 = 2'd2;
    localparam logic [SEL_W-1:0] SEL_IN4 = 2'd3;

endpackage

// File: rtl/mux4_reg_if.sv
// mux4_reg_if: operand/select/result bundle for mux4_reg.
//   ctrl    : 2-bit operand select
//   in1-in4 : DATA_W-bit operands
//   out     : registered selected operand
//   out_par : registered XOR-reduction of the selection (only with MUX4_REG_PARITY_EN)
// master drives the operands and select; slave is the multiplexer.
interface mux4_reg_if
    import mux4_reg_pkg::*;
#(
    parameter int unsigned DATA_W = mux4_reg_pkg::DATA_W_DEFAULT
) ();

    logic [SEL_W-1:0]  ctrl;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] in3;
    logic [DATA_W-1:0] in4;
    logic [DATA_W-1:0] out;
`ifdef MUX4_REG_PARITY_EN
    logic              out_par;

    modport master (output ctrl, in1, in2, in3, in4, input out, out_par);
    modport slave  (input ctrl, in1, in2, in3, in4, output out, out_par);
`else
    modport master (output ctrl, in1, in2, in3, in4, input out);
    modport slave  (input ctrl, in1, in2, in3, in4, output out);
`endif

endinterface

// File: rtl/mux4_sel.sv
// mux4_sel: purely combinational DATA_W-wide 4:1 select.
//   ctrl    : select (package SEL_IN* encodings)
//   in1-in4 : operands
//   out_c   : selected operand (combinational)
module mux4_sel
    import mux4_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic [SEL_W-1:0]  ctrl,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    output logic [DATA_W-1:0] out_c
);

    // Full case; the default arm also absorbs X/Z select values in simulation.
    always_comb begin
        out_c = in1;
        case (ctrl)
            SEL_IN1: out_c = in1;
            SEL_IN2: out_c = in2;
            SEL_IN3: out_c = in3;
            SEL_IN4: out_c = in4;
            default: out_c = in1;
        endcase
    end

endmodule

// File: rtl/mux4_reg.sv
// mux4_reg: registered 4:1 operand multiplexer, one clock of latency.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, clears the output register(s)
//   bus : mux4_reg_if slave (ctrl, in1-in4 in; out, optional out_par registered)
// Build option: define MUX4_REG_PARITY_EN to add the registered out_par bit.
module mux4_reg
    import mux4_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    mux4_reg_if.slave  bus
);

    logic [DATA_W-1:0] sel_c;

    mux4_sel #(
        .DATA_W (DATA_W)
    ) u_sel (
        .ctrl  (bus.ctrl),
        .in1   (bus.in1),
        .in2   (bus.in2),
        .in3   (bus.in3),
        .in4   (bus.in4),
        .out_c (sel_c)
    );

    // Output register; reset discards whatever selection is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out <= '0;
        end else begin
            bus.out <= sel_c;
        end
    end

`ifdef MUX4_REG_PARITY_EN
    // Parity of the same selection, registered in step with out.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_par <= 1'b0;
        end else begin
            bus.out_par <= ^sel_c;
        end
    end
`endif

endmodule

// File: tb/tb_mux4_reg.sv
// tb_mux4_reg: scoreboard bench for mux4_reg. Stimulus pushes the expected
// result of each issued cycle into a queue; a monitor pops and compares one
// clock later, on the falling edge.
module tb_mux4_reg;

    localparam int unsigned DW = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          par;
    } exp_t;

    logic clk;
    logic rst;
    logic issued;
    int   total;
    int   bad;
    exp_t exp_q[$];

    mux4_reg_if #(.DATA_W(DW)) bus ();

    mux4_reg #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: what out must hold after an edge with these inputs.
    function automatic exp_t model(input logic r, input logic [1:0] c,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] cc, input logic [DW-1:0] d);
        logic [DW-1:0] ops [4];
        exp_t e;
        ops[0] = a; ops[1] = b; ops[2] = cc; ops[3] = d;
        if (r) begin
            e.data = '0;
            e.par  = 1'b0;
        end else begin
            e.data = ops[int'(c)];
            e.par  = ^ops[int'(c)];
        end
        return e;
    endfunction

    task automatic cyc(input logic r, input logic [1:0] c,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] cc, input logic [DW-1:0] d);
        @(negedge clk);
        #1;
        rst      = r;
        bus.ctrl = c;
        bus.in1  = a;
        bus.in2  = b;
        bus.in3  = cc;
        bus.in4  = d;
        issued   = 1'b1;
        exp_q.push_back(model(r, c, a, b, cc, d));
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        rst    = 1'b0;
        issued = 1'b0;
    endtask

    // Monitor: result of a cycle issued before edge k is checked after edge k.
    initial begin
        logic had;
        exp_t e;
        forever begin
            @(posedge clk);
            had = issued;
            @(negedge clk);
            if (had) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard: output with empty queue at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out", bus.out, e.data);
`ifdef MUX4_REG_PARITY_EN
                    chk("out_par", DW'(bus.out_par), DW'(e.par));
`endif
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] r1, r2, r3, r4, v;
        logic [1:0]    rc;
        logic          rr;
        int            wait_cnt;
        total    = 0;
        bad      = 0;
        issued   = 1'b0;
        rst      = 1'b1;
        bus.ctrl = 2'd3;
        bus.in1  = 64'd1;
        bus.in2  = 64'd2;
        bus.in3  = 64'd3;
        bus.in4  = 64'd4;

        // Reset held two edges with nonzero inputs, then release.
        cyc(1'b1, 2'd3, 64'd11, 64'd22, 64'd33, 64'd44);
        cyc(1'b1, 2'd3, 64'd11, 64'd22, 64'd33, 64'd44);
        cyc(1'b0, 2'd3, 64'd11, 64'd22, 64'd33, 64'd44);

        // Each select in turn.
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 2'(i), 64'd10, 64'd20, 64'd30, 64'd40);

        // Wide values pass unmodified.
        cyc(1'b0, 2'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd0);
        cyc(1'b0, 2'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd0);

        // Hold: in1 changes between edges, out keeps the old value until the edge.
        cyc(1'b0, 2'd0, 64'd5, 64'd0, 64'd0, 64'd0);
        cyc(1'b0, 2'd0, 64'd7, 64'd0, 64'd0, 64'd0);
        #1;
        chk("hold", bus.out, 64'd5);

        // Mid-stream reset pulse while ctrl cycles.
        for (int i = 0; i < 8; i++)
            cyc(i == 5, 2'(i), 64'hA1, 64'hB2, 64'hC3, 64'hD4);

        // Identical inputs: ctrl is irrelevant.
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 2'(i), 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
                64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);

        // Parity pair.
        cyc(1'b0, 2'd0, 64'h3, 64'h7, 64'd0, 64'd0);
        cyc(1'b0, 2'd1, 64'h3, 64'h7, 64'd0, 64'd0);

        // Randomized back-to-back traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            r3 = {$urandom, $urandom};
            r4 = {$urandom, $urandom};
            rc = 2'($urandom_range(3, 0));
            rr = ($urandom_range(15, 0) == 0);
            cyc(rr, rc, r1, r2, r3, r4);
            if ($urandom_range(7, 0) == 0) idle();
        end

        // Reset after idle, then one more selection.
        idle();
        v = 64'hDEAD_BEEF_0000_0001;
        cyc(1'b1, 2'd2, v, v, v, v);
        cyc(1'b0, 2'd2, 64'd0, 64'd0, v, 64'd0);
        idle();

        // Drain the scoreboard within a bounded number of cycles.
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        repeat (2) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
